// File: rtl/bt_pkg.sv
// Shared types and default command codes for the Bluetooth command decoder.
package bt_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] CMD_VOL_DN = 8'hB0;
    localparam logic [7:0] CMD_VOL_UP = 8'hB1;
    localparam logic [7:0] CMD_NEXT   = 8'hB2;
    localparam logic [7:0] CMD_PREV   = 8'hB3;
    localparam logic [7:0] CMD_RST    = 8'hB4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser.
module uart_rx
    import bt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic            sync1, rx_s;
    rx_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [7:0]      byte_n;
    logic            wait_hi, wait_n;
    logic            bv_n, fe_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            wait_hi    <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= data_in;
            rx_s       <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            wait_hi    <= wait_n;
            rx_byte    <= byte_n;
            byte_valid <= bv_n;
            frame_err  <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        wait_n  = wait_hi;
        byte_n  = rx_byte;
        bv_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                // a broken frame leaves the line low; wait for idle first
                if (wait_hi) begin
                    if (rx_s) wait_n = 1'b0;
                end else if (!rx_s) begin
                    state_n = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_s) begin
                        bv_n   = 1'b1;
                        byte_n = shreg;
                    end else begin
                        fe_n   = 1'b1;
                        wait_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/bt_cmd_decoder.sv
// Bluetooth UART command decoder: byte codes to one-hot command pulses,
// with repeat guard, stretched reset request and error counting.
module bt_cmd_decoder
    import bt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 5208,
    parameter int         NUM_CMDS     = 8,
    parameter logic [7:0] CMD_BASE     = CMD_VOL_DN,
    parameter int         RST_IDX      = 4,
    parameter int         RST_HOLD     = 16,
    parameter int         GUARD_CYCLES = 0
) (
    input  logic                Bluetooth_clk,
    input  logic                rst_n,
    input  logic                data_in,
    output logic [NUM_CMDS-1:0] cmd_pulse,
    output logic                bt_rst_n,
    output logic [7:0]          last_cmd,
    output logic                frame_err,
    output logic                unknown_cmd,
    output logic [7:0]          err_cnt
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic [7:0]    off;
    logic          in_range, guarded, accept, is_rst, bad;
    logic [GW-1:0] guard_cnt;
    logic [HW-1:0] hold_cnt;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (Bluetooth_clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign off      = rx_byte - CMD_BASE;
    assign in_range = (rx_byte >= CMD_BASE) && (off < 8'(NUM_CMDS));
    assign guarded  = (GUARD_CYCLES > 0) && (guard_cnt != '0)
                      && (rx_byte == last_cmd);
    assign accept   = byte_valid && in_range && !guarded;
    assign is_rst   = accept && (off == 8'(RST_IDX));
    assign bad      = frame_err || (byte_valid && !in_range);

    always_ff @(posedge Bluetooth_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_pulse   <= '0;
            bt_rst_n    <= 1'b1;
            last_cmd    <= '0;
            unknown_cmd <= 1'b0;
            err_cnt     <= '0;
            guard_cnt   <= '0;
            hold_cnt    <= '0;
        end else begin
            cmd_pulse   <= accept ? (NUM_CMDS'(1) << off[3:0]) : '0;
            unknown_cmd <= byte_valid && !in_range;
            if (accept) last_cmd <= rx_byte;

            if (accept)
                guard_cnt <= GW'(GUARD_CYCLES);
            else if (guard_cnt != '0)
                guard_cnt <= guard_cnt - GW'(1);

            // a repeated reset command while held low restarts the hold
            if (is_rst) begin
                hold_cnt <= HW'(RST_HOLD);
                bt_rst_n <= 1'b0;
            end else if (hold_cnt == HW'(1)) begin
                hold_cnt <= '0;
                bt_rst_n <= 1'b1;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Randomised self-checking bench for bt_cmd_decoder against a byte-level model.
module tb_bt_cmd_decoder;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n [3];
    logic       line  [3];
    logic [7:0] cp    [3];
    logic       brn   [3];
    logic [7:0] lc    [3];
    logic       fe    [3];
    logic       unk   [3];
    logic [7:0] ec    [3];

    always #5 clk = ~clk;

    bt_cmd_decoder #(.CLKS_PER_BIT(CPB)) dut0 (
        .Bluetooth_clk(clk), .rst_n(rst_n[0]), .data_in(line[0]),
        .cmd_pulse(cp[0]), .bt_rst_n(brn[0]), .last_cmd(lc[0]),
        .frame_err(fe[0]), .unknown_cmd(unk[0]), .err_cnt(ec[0]));

    bt_cmd_decoder #(.CLKS_PER_BIT(CPB), .GUARD_CYCLES(400)) dut1 (
        .Bluetooth_clk(clk), .rst_n(rst_n[1]), .data_in(line[1]),
        .cmd_pulse(cp[1]), .bt_rst_n(brn[1]), .last_cmd(lc[1]),
        .frame_err(fe[1]), .unknown_cmd(unk[1]), .err_cnt(ec[1]));

    bt_cmd_decoder #(.CLKS_PER_BIT(CPB), .RST_HOLD(200)) dut2 (
        .Bluetooth_clk(clk), .rst_n(rst_n[2]), .data_in(line[2]),
        .cmd_pulse(cp[2]), .bt_rst_n(brn[2]), .last_cmd(lc[2]),
        .frame_err(fe[2]), .unknown_cmd(unk[2]), .err_cnt(ec[2]));

    int checks = 0;
    int failures = 0;
    longint cyc = 0;

    int n_pulse [3] = '{0, 0, 0};
    int n_unk   [3] = '{0, 0, 0};
    int n_fe    [3] = '{0, 0, 0};
    int n_lowe  [3] = '{0, 0, 0};
    int low_run [3] = '{0, 0, 0};
    int last_low[3] = '{0, 0, 0};
    int bad_hot [3] = '{0, 0, 0};
    logic [7:0] last_pulse [3];

    // byte-level reference state
    logic [7:0] m_last  [3];
    int         m_err   [3];
    longint     m_gu    [3];
    int         guard_of[3] = '{0, 400, 0};
    logic [7:0] prev    [3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (cp[d] != 8'h00) begin
                n_pulse[d]++;
                last_pulse[d] = cp[d];
                if ($countones(cp[d]) != 1) bad_hot[d]++;
            end
            if (unk[d]) n_unk[d]++;
            if (fe[d]) n_fe[d]++;
            if (!brn[d]) begin
                low_run[d]++;
            end else if (low_run[d] != 0) begin
                last_low[d] = low_run[d];
                n_lowe[d]++;
                low_run[d] = 0;
            end
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b,
                        input bit good, input int gap);
        line[d] = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            line[d] = b[i];
            repeat (CPB) @(posedge clk);
        end
        line[d] = good;
        repeat (CPB) @(posedge clk);
        line[d] = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic bump_err(input int d);
        if (m_err[d] < 255) m_err[d]++;
    endtask

    task automatic model_reset(input int d);
        m_last[d] = 8'h00;
        m_err[d]  = 0;
        m_gu[d]   = 0;
    endtask

    task automatic chk_reset(input int d);
        chk("rst_pulse", cp[d], 0);
        chk("rst_btrst", brn[d], 1);
        chk("rst_last", lc[d], 0);
        chk("rst_fe", fe[d], 0);
        chk("rst_unk", unk[d], 0);
        chk("rst_err", ec[d], 0);
    endtask

    task automatic do_byte(input int d, input logic [7:0] b, input bit good,
                           input int gap, output longint t0);
        int p0, u0, f0;
        int e_p, e_u, e_f;
        logic [7:0] e_val;
        p0 = n_pulse[d];
        u0 = n_unk[d];
        f0 = n_fe[d];
        e_p = 0;
        e_u = 0;
        e_f = 0;
        e_val = 8'h00;
        t0 = cyc;
        send(d, b, good, gap);
        if (!good) begin
            e_f = 1;
            bump_err(d);
        end else if (b >= 8'hB0 && b < 8'hB8) begin
            if (!(guard_of[d] > 0 && b == m_last[d] && t0 < m_gu[d])) begin
                e_p = 1;
                e_val = 8'h01 << (b - 8'hB0);
                m_last[d] = b;
                m_gu[d] = t0 + guard_of[d];
            end
        end else begin
            e_u = 1;
            bump_err(d);
        end
        prev[d] = b;
        settle();
        chk("pulses", n_pulse[d] - p0, e_p);
        if (e_p != 0) chk("pulse_val", last_pulse[d], e_val);
        chk("unknown", n_unk[d] - u0, e_u);
        chk("frame_err", n_fe[d] - f0, e_f);
        chk("last_cmd", lc[d], m_last[d]);
        chk("err_cnt", ec[d], m_err[d]);
        chk("onehot", bad_hot[d], 0);
    endtask

    initial begin
        longint t1, t2, tx;
        int p0, u0, f0, e0, d;
        logic [7:0] b;
        int r;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            line[i]  = 1'b1;
            prev[i]  = 8'hB0;
            model_reset(i);
        end
        repeat (5) @(posedge clk);
        settle();
        for (int i = 0; i < 3; i++) chk_reset(i);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        repeat (5) @(posedge clk);

        do_byte(0, 8'hB2, 1'b1, 10, tx);

        e0 = n_lowe[0];
        do_byte(0, 8'hB4, 1'b1, 30, tx);
        chk("rst_low_len", last_low[0], 16);
        chk("rst_low_ev", n_lowe[0] - e0, 1);

        e0 = n_lowe[2];
        do_byte(2, 8'hB4, 1'b1, 4, t1);
        do_byte(2, 8'hB4, 1'b1, 250, t2);
        chk("rst_retrig_len", last_low[2], t2 - t1 + 200);
        chk("rst_retrig_ev", n_lowe[2] - e0, 1);

        do_byte(0, 8'hC0, 1'b1, 10, tx);
        do_byte(0, 8'hAF, 1'b1, 10, tx);

        do_byte(0, 8'hB1, 1'b0, 10, tx);
        do_byte(0, 8'hB1, 1'b1, 10, tx);

        p0 = n_pulse[0];
        u0 = n_unk[0];
        f0 = n_fe[0];
        line[0] = 1'b0;
        repeat (8) @(posedge clk);
        line[0] = 1'b1;
        repeat (40) @(posedge clk);
        settle();
        chk("glitch_pulse", n_pulse[0] - p0, 0);
        chk("glitch_unk", n_unk[0] - u0, 0);
        chk("glitch_fe", n_fe[0] - f0, 0);
        chk("glitch_err", ec[0], m_err[0]);
        do_byte(0, 8'hB0, 1'b1, 10, tx);

        do_byte(1, 8'hB3, 1'b1, 4, tx);
        do_byte(1, 8'hB3, 1'b1, 500, tx);
        do_byte(1, 8'hB3, 1'b1, 4, tx);
        do_byte(1, 8'hB0, 1'b1, 4, tx);
        do_byte(1, 8'hB3, 1'b1, 10, tx);

        line[1] = 1'b0;
        repeat (CPB * 4) @(posedge clk);
        rst_n[1] = 1'b0;
        settle();
        chk_reset(1);
        model_reset(1);
        line[1] = 1'b1;
        repeat (5) @(posedge clk);
        rst_n[1] = 1'b1;
        repeat (5) @(posedge clk);
        do_byte(1, 8'hB2, 1'b1, 10, tx);

        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 5)
                b = 8'hB0 + 8'($urandom_range(0, 7));
            else if (r < 7)
                b = prev[d];
            else
                b = 8'($urandom);
            do_byte(d, b, $urandom_range(0, 9) != 0,
                    ($urandom_range(0, 7) == 0) ? 450
                                                : int'($urandom_range(4, 30)),
                    tx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
